// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared widths, FSM states and master tags for the SRAM-port arbiter.
package axi_arb_pkg;
   localparam int AXI_ID_BITS   = 4;
   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;
   localparam int AXI_STRB_BITS = 4;
   typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t;
   localparam logic [3:0] M0_TAG = 4'd0;
   localparam logic [3:0] M1_TAG = 4'd1;
   localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin arbiter; priority starts after the last granted request.
module rr_arbiter3 (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic       upd,
   output logic [2:0] gnt
);
   logic [1:0] last_q, last_d;
   logic [2:0] rot, pri;
   always_comb begin
      // rotate so bit 0 is the candidate right after the last grant
      rot = last_q == 2'd0 ? {req[0], req[2], req[1]} : last_q == 2'd1 ? {req[1], req[0], req[2]} : req;
      pri = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
      gnt = last_q == 2'd0 ? {pri[1], pri[0], pri[2]} : last_q == 2'd1 ? {pri[0], pri[2], pri[1]} : pri;
      last_d = upd ? (gnt[0] ? 2'd0 : gnt[1] ? 2'd1 : 2'd2) : last_q;
   end
   always_ff @(posedge clk) last_q <= rst ? 2'd2 : last_d;
endmodule

// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter: shares the SRAM slave port between fetch (M0) and load/store (M1), one burst at a time.
// Define ARB_FIXED_PRIO_EN for fixed priority AW_M1 > AR_M1 > AR_M0 instead of round-robin.
module axi_sram_arbiter import axi_arb_pkg::*; (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [AXI_ID_BITS-1:0]   ARID_M0,
   input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
   input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
   input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
   input  logic [1:0]               ARBURST_M0,
   input  logic                     ARVALID_M0,
   output logic                     ARREADY_M0,
   output logic [AXI_ID_BITS-1:0]   RID_M0,
   output logic [AXI_DATA_BITS-1:0] RDATA_M0,
   output logic [1:0]               RRESP_M0,
   output logic                     RLAST_M0,
   output logic                     RVALID_M0,
   input  logic                     RREADY_M0,
   input  logic [AXI_ID_BITS-1:0]   ARID_M1,
   input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
   input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
   input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
   input  logic [1:0]               ARBURST_M1,
   input  logic                     ARVALID_M1,
   output logic                     ARREADY_M1,
   output logic [AXI_ID_BITS-1:0]   RID_M1,
   output logic [AXI_DATA_BITS-1:0] RDATA_M1,
   output logic [1:0]               RRESP_M1,
   output logic                     RLAST_M1,
   output logic                     RVALID_M1,
   input  logic                     RREADY_M1,
   input  logic [AXI_ID_BITS-1:0]   AWID_M1,
   input  logic [AXI_ADDR_BITS-1:0] AWADDR_M1,
   input  logic [AXI_LEN_BITS-1:0]  AWLEN_M1,
   input  logic [AXI_SIZE_BITS-1:0] AWSIZE_M1,
   input  logic [1:0]               AWBURST_M1,
   input  logic                     AWVALID_M1,
   output logic                     AWREADY_M1,
   input  logic [AXI_DATA_BITS-1:0] WDATA_M1,
   input  logic [AXI_STRB_BITS-1:0] WSTRB_M1,
   input  logic                     WLAST_M1,
   input  logic                     WVALID_M1,
   output logic                     WREADY_M1,
   output logic [AXI_ID_BITS-1:0]   BID_M1,
   output logic [1:0]               BRESP_M1,
   output logic                     BVALID_M1,
   input  logic                     BREADY_M1,
   output logic [AXI_IDS_BITS-1:0]  ARID_S,
   output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
   output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
   output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
   output logic [1:0]               ARBURST_S,
   output logic                     ARVALID_S,
   input  logic                     ARREADY_S,
   input  logic [AXI_IDS_BITS-1:0]  RID_S,
   input  logic [AXI_DATA_BITS-1:0] RDATA_S,
   input  logic [1:0]               RRESP_S,
   input  logic                     RLAST_S,
   input  logic                     RVALID_S,
   output logic                     RREADY_S,
   output logic [AXI_IDS_BITS-1:0]  AWID_S,
   output logic [AXI_ADDR_BITS-1:0] AWADDR_S,
   output logic [AXI_LEN_BITS-1:0]  AWLEN_S,
   output logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
   output logic [1:0]               AWBURST_S,
   output logic                     AWVALID_S,
   input  logic                     AWREADY_S,
   output logic [AXI_DATA_BITS-1:0] WDATA_S,
   output logic [AXI_STRB_BITS-1:0] WSTRB_S,
   output logic                     WLAST_S,
   output logic                     WVALID_S,
   input  logic                     WREADY_S,
   input  logic [AXI_IDS_BITS-1:0]  BID_S,
   input  logic [1:0]               BRESP_S,
   input  logic                     BVALID_S,
   output logic                     BREADY_S
);
   arb_state_t state_q, state_d;
   logic [2:0] req, gnt;
   logic idle, rd, wr, ar_hs, aw_hs, w_en, to_m0, unused_bid;
   assign req = {AWVALID_M1, ARVALID_M1, ARVALID_M0};
`ifdef ARB_FIXED_PRIO_EN
   assign gnt = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
`else
   rr_arbiter3 u_rr (.clk(ACLK), .rst(ARESET), .req(req), .upd(ar_hs | aw_hs), .gnt(gnt));
`endif
   always_comb begin
      idle = state_q == IDLE;
      rd = state_q == RD;
      wr = state_q == WR;
      ARID_S = gnt[1] ? {M1_TAG, ARID_M1} : gnt[0] ? {M0_TAG, ARID_M0} : '0;
      ARADDR_S = gnt[1] ? ARADDR_M1 : gnt[0] ? ARADDR_M0 : '0;
      ARLEN_S = gnt[1] ? ARLEN_M1 : gnt[0] ? ARLEN_M0 : '0;
      ARSIZE_S = gnt[1] ? ARSIZE_M1 : gnt[0] ? ARSIZE_M0 : '0;
      ARBURST_S = gnt[1] ? ARBURST_M1 : gnt[0] ? ARBURST_M0 : '0;
      ARVALID_S = idle & (gnt[0] | gnt[1]);
      ARREADY_M0 = idle & gnt[0] & ARREADY_S;
      ARREADY_M1 = idle & gnt[1] & ARREADY_S;
      AWID_S = gnt[2] ? {M1_TAG, AWID_M1} : '0;
      AWADDR_S = gnt[2] ? AWADDR_M1 : '0;
      AWLEN_S = gnt[2] ? AWLEN_M1 : '0;
      AWSIZE_S = gnt[2] ? AWSIZE_M1 : '0;
      AWBURST_S = gnt[2] ? AWBURST_M1 : '0;
      AWVALID_S = idle & gnt[2];
      AWREADY_M1 = idle & gnt[2] & AWREADY_S;
      // W may ride along with the winning AW so AW and the first beat can share a cycle
      w_en = wr | (idle & gnt[2]);
      WDATA_S = w_en ? WDATA_M1 : '0;
      WSTRB_S = w_en ? WSTRB_M1 : '0;
      WLAST_S = w_en & WLAST_M1;
      WVALID_S = w_en & WVALID_M1;
      WREADY_M1 = w_en & WREADY_S;
      to_m0 = RID_S[7:4] == M0_TAG;
      RID_M0 = RID_S[3:0];
      RID_M1 = RID_S[3:0];
      RDATA_M0 = RDATA_S;
      RDATA_M1 = RDATA_S;
      RRESP_M0 = RRESP_S;
      RRESP_M1 = RID_S[7:4] == M1_TAG ? RRESP_S : DECERR;
      RLAST_M0 = RLAST_S;
      RLAST_M1 = RLAST_S;
      RVALID_M0 = rd & to_m0 & RVALID_S;
      RVALID_M1 = rd & ~to_m0 & RVALID_S;
      RREADY_S = rd & (to_m0 ? RREADY_M0 : RREADY_M1);
      BID_M1 = BID_S[3:0];
      unused_bid = ^BID_S[7:4];
      BRESP_M1 = BRESP_S;
      BVALID_M1 = wr & BVALID_S;
      BREADY_S = wr & BREADY_M1;
      ar_hs = ARVALID_S & ARREADY_S;
      aw_hs = AWVALID_S & AWREADY_S;
      state_d = idle ? (ar_hs ? RD : aw_hs ? WR : IDLE)
              : rd ? ((RVALID_S & RREADY_S & RLAST_S) ? IDLE : RD)
              : ((BVALID_S & BREADY_S) ? IDLE : WR);
   end
   always_ff @(posedge ACLK) state_q <= ARESET ? IDLE : state_d;
endmodule

// File: tb/tb_axi_sram_arbiter.sv
// tb_axi_sram_arbiter: directed and randomized checks of grant order, routing and reset against a transaction model.
module tb_axi_sram_arbiter;
   import axi_arb_pkg::*;
   logic ACLK = 1'b0;
   logic ARESET;
   logic [3:0] ARID_M0, ARLEN_M0, RID_M0, ARID_M1, ARLEN_M1, RID_M1, AWID_M1, AWLEN_M1, BID_M1;
   logic [3:0] ARLEN_S, AWLEN_S, WSTRB_M1, WSTRB_S;
   logic [31:0] ARADDR_M0, RDATA_M0, ARADDR_M1, RDATA_M1, AWADDR_M1, WDATA_M1;
   logic [31:0] ARADDR_S, RDATA_S, AWADDR_S, WDATA_S;
   logic [2:0] ARSIZE_M0, ARSIZE_M1, AWSIZE_M1, ARSIZE_S, AWSIZE_S;
   logic [1:0] ARBURST_M0, ARBURST_M1, AWBURST_M1, ARBURST_S, AWBURST_S;
   logic [1:0] RRESP_M0, RRESP_M1, BRESP_M1, RRESP_S, BRESP_S;
   logic [7:0] ARID_S, RID_S, AWID_S, BID_S;
   logic ARVALID_M0, ARREADY_M0, RLAST_M0, RVALID_M0, RREADY_M0;
   logic ARVALID_M1, ARREADY_M1, RLAST_M1, RVALID_M1, RREADY_M1;
   logic AWVALID_M1, AWREADY_M1, WLAST_M1, WVALID_M1, WREADY_M1, BVALID_M1, BREADY_M1;
   logic ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, AWVALID_S, AWREADY_S;
   logic WLAST_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;

   axi_sram_arbiter dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
      .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
      .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
      .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
      .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
      .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
      .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
      .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
      .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWSIZE_M1(AWSIZE_M1),
      .AWBURST_M1(AWBURST_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
      .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1), .WVALID_M1(WVALID_M1),
      .WREADY_M1(WREADY_M1), .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1),
      .BREADY_M1(BREADY_M1),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
      .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
      .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
      .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
      .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
      .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
      .BREADY_S(BREADY_S)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errs = 0;
   // model: candidates 0=AR_M0, 1=AR_M1, 2=AW_M1; last = most recently granted candidate
   int last;
   bit pend [3];
   logic [3:0] rid [3];
   logic [31:0] raddr [3];
   logic [3:0] rlen [3];
   logic [31:0] wd [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner();
`ifdef ARB_FIXED_PRIO_EN
      for (int k = 2; k >= 0; k--) if (pend[k]) return k;
`else
      for (int k = 1; k <= 3; k++) if (pend[(last + k) % 3]) return (last + k) % 3;
`endif
      return -1;
   endfunction

   task automatic add_req(input int k, input logic [31:0] a, input logic [3:0] l);
      if (!pend[k]) begin
         pend[k] = 1'b1;
         rid[k] = 4'($urandom);
         raddr[k] = a;
         rlen[k] = l;
         if (k == 2) for (int b = 0; b < 16; b++) wd[b] = $urandom;
      end
   endtask

   task automatic drive_reqs();
      ARVALID_M0 = pend[0]; ARID_M0 = rid[0]; ARADDR_M0 = raddr[0]; ARLEN_M0 = rlen[0];
      ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
      ARVALID_M1 = pend[1]; ARID_M1 = rid[1]; ARADDR_M1 = raddr[1]; ARLEN_M1 = rlen[1];
      ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01;
      AWVALID_M1 = pend[2]; AWID_M1 = rid[2]; AWADDR_M1 = raddr[2]; AWLEN_M1 = rlen[2];
      AWSIZE_M1 = 3'd2; AWBURST_M1 = 2'b01;
      WVALID_M1 = pend[2]; WDATA_M1 = wd[0]; WSTRB_M1 = 4'hf; WLAST_M1 = rlen[2] == 4'd0;
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic no_addr_grant(input string tag);
      chk({tag, "_arready_m0"}, ARREADY_M0, 1'b0);
      chk({tag, "_arready_m1"}, ARREADY_M1, 1'b0);
      chk({tag, "_awready_m1"}, AWREADY_M1, 1'b0);
      chk({tag, "_arvalid_s"}, ARVALID_S, 1'b0);
      chk({tag, "_awvalid_s"}, AWVALID_S, 1'b0);
   endtask

   // one full transaction from the idle cycle; ftag >= 0 overrides the slave's RID tag,
   // rst_beat >= 0 resets the system on that read beat
   task automatic run_txn(input bit add_en, input int ftag, input int rst_beat);
      int w, nb, bt;
      bit done, ok, rr, to_m0, lst;
      logic [3:0] tid, tl, tag;
      logic [31:0] d;
      logic [1:0] rs;
      drive_reqs();
      ARREADY_S = 1'b1; AWREADY_S = 1'b1; WREADY_S = 1'b1; RVALID_S = 1'b0; BVALID_S = 1'b0;
      RREADY_M0 = 1'b1; RREADY_M1 = 1'b1; BREADY_M1 = 1'b1;
      #1;
      w = winner();
      chk("grant_arvalid_s", ARVALID_S, w == 0 || w == 1);
      chk("grant_awvalid_s", AWVALID_S, w == 2);
      chk("grant_arready_m0", ARREADY_M0, w == 0);
      chk("grant_arready_m1", ARREADY_M1, w == 1);
      chk("grant_awready_m1", AWREADY_M1, w == 2);
      chk("grant_wvalid_s", WVALID_S, w == 2);
      if (w == 0 || w == 1) begin
         chk("arid_s", ARID_S, {4'(w), rid[w]});
         chk("araddr_s", ARADDR_S, raddr[w]);
         chk("arlen_s", ARLEN_S, rlen[w]);
      end
      if (w == 2) begin
         chk("awid_s", AWID_S, {4'd1, rid[2]});
         chk("awaddr_s", AWADDR_S, raddr[2]);
         chk("awlen_s", AWLEN_S, rlen[2]);
         chk("wdata0_s", WDATA_S, wd[0]);
      end
      if (w < 0) begin
         tick();
         return;
      end
      tid = rid[w];
      tl = rlen[w];
      tag = ftag >= 0 ? 4'(ftag) : 4'(w);
      last = w;
      pend[w] = 1'b0;
      tick();
      if (add_en) begin
         if ($urandom % 2 == 1) add_req(0, $urandom, 4'($urandom_range(0, 7)));
         if ($urandom % 2 == 1) add_req(1, $urandom, 4'($urandom_range(0, 7)));
         if (w != 2 && $urandom % 2 == 1) add_req(2, $urandom, 4'($urandom_range(0, 7)));
      end
      drive_reqs();
      if (w == 2) begin
         nb = 1;
         for (int n = 0; n < 200 && nb <= 32'(tl); n++) begin
            WVALID_M1 = 1'b1; WDATA_M1 = wd[nb]; WLAST_M1 = nb == 32'(tl);
            ok = 1'($urandom);
            WREADY_S = ok;
            #1;
            chk("w_wvalid_s", WVALID_S, 1'b1);
            chk("w_wdata_s", WDATA_S, wd[nb]);
            chk("w_wlast_s", WLAST_S, nb == 32'(tl));
            chk("w_wready_m1", WREADY_M1, ok);
            no_addr_grant("w");
            tick();
            if (ok) nb++;
         end
         chk("w_beats", nb, 32'(tl) + 1);
         WVALID_M1 = 1'b0;
         done = 1'b0;
         for (int n = 0; n < 200 && !done; n++) begin
            rs = 2'($urandom);
            ok = 1'($urandom);
            BVALID_S = 1'b1; BID_S = {4'd1, tid}; BRESP_S = rs; BREADY_M1 = ok;
            #1;
            chk("b_bvalid_m1", BVALID_M1, 1'b1);
            chk("b_bid_m1", BID_M1, tid);
            chk("b_bresp_m1", BRESP_M1, rs);
            chk("b_bready_s", BREADY_S, ok);
            no_addr_grant("b");
            tick();
            done = ok;
         end
         chk("b_done", done, 1'b1);
         BVALID_S = 1'b0;
      end else begin
         bt = 0;
         done = 1'b0;
         to_m0 = tag == 4'd0;
         for (int n = 0; n < 200 && !done; n++) begin
            d = $urandom;
            rs = 2'($urandom_range(0, 2));
            rr = 1'($urandom);
            lst = bt == 32'(tl);
            RVALID_S = 1'b1; RID_S = {tag, tid}; RDATA_S = d; RRESP_S = rs; RLAST_S = lst;
            RREADY_M0 = to_m0 ? rr : !rr;
            RREADY_M1 = to_m0 ? !rr : rr;
            if (bt == rst_beat) ARESET = 1'b1;
            #1;
            chk("r_rvalid_m0", RVALID_M0, to_m0);
            chk("r_rvalid_m1", RVALID_M1, !to_m0);
            chk("r_rdata", to_m0 ? RDATA_M0 : RDATA_M1, d);
            chk("r_rid", to_m0 ? RID_M0 : RID_M1, tid);
            chk("r_rlast", to_m0 ? RLAST_M0 : RLAST_M1, lst);
            chk("r_rresp", to_m0 ? RRESP_M0 : RRESP_M1, (tag == 4'd0 || tag == 4'd1) ? rs : 2'b11);
            chk("r_rready_s", RREADY_S, rr);
            chk("r_wvalid_s", WVALID_S, 1'b0);
            chk("r_wready_m1", WREADY_M1, 1'b0);
            no_addr_grant("r");
            if (ARESET) begin
               tick();
               ARESET = 1'b0;
               last = 2;
               pend[0] = 1'b0; pend[1] = 1'b0; pend[2] = 1'b0;
               drive_reqs();
               RREADY_M0 = 1'b1; RREADY_M1 = 1'b1; BVALID_S = 1'b1; BREADY_M1 = 1'b1;
               #1;
               chk("rst_rvalid_m0", RVALID_M0, 1'b0);
               chk("rst_rvalid_m1", RVALID_M1, 1'b0);
               chk("rst_bvalid_m1", BVALID_M1, 1'b0);
               chk("rst_rready_s", RREADY_S, 1'b0);
               chk("rst_bready_s", BREADY_S, 1'b0);
               chk("rst_wvalid_s", WVALID_S, 1'b0);
               no_addr_grant("rst");
               RVALID_S = 1'b0; BVALID_S = 1'b0; RLAST_S = 1'b0;
               return;
            end
            tick();
            if (rr) begin
               done = lst;
               bt++;
            end
         end
         chk("r_done", done, 1'b1);
         RVALID_S = 1'b0; RLAST_S = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && (pend[0] || pend[1] || pend[2]); i++) run_txn(1'b0, -1, -1);
   endtask

   initial begin
      last = 2;
      for (int k = 0; k < 3; k++) begin
         pend[k] = 1'b0; rid[k] = '0; raddr[k] = '0; rlen[k] = '0;
      end
      for (int b = 0; b < 16; b++) wd[b] = '0;
      drive_reqs();
      RREADY_M0 = 1'b0; RREADY_M1 = 1'b0; BREADY_M1 = 1'b0;
      ARREADY_S = 1'b0; AWREADY_S = 1'b0; WREADY_S = 1'b0;
      RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
      BID_S = '0; BRESP_S = '0; BVALID_S = 1'b0;
      ARESET = 1'b1;
      tick();
      tick();
      ARESET = 1'b0;
      // stray slave responses and readies must not leak through an idle arbiter
      ARREADY_S = 1'b1; AWREADY_S = 1'b1; WREADY_S = 1'b1; RVALID_S = 1'b1; BVALID_S = 1'b1;
      RREADY_M0 = 1'b1; RREADY_M1 = 1'b1; BREADY_M1 = 1'b1; WVALID_M1 = 1'b1;
      #1;
      chk("reset_rvalid_m0", RVALID_M0, 1'b0);
      chk("reset_rvalid_m1", RVALID_M1, 1'b0);
      chk("reset_bvalid_m1", BVALID_M1, 1'b0);
      chk("reset_rready_s", RREADY_S, 1'b0);
      chk("reset_bready_s", BREADY_S, 1'b0);
      chk("reset_wvalid_s", WVALID_S, 1'b0);
      chk("reset_wready_m1", WREADY_M1, 1'b0);
      no_addr_grant("reset");
      RVALID_S = 1'b0; BVALID_S = 1'b0; WVALID_M1 = 1'b0;
      tick();
      // both reads pending straight after reset, twice
      for (int r = 0; r < 2; r++) begin
         add_req(0, $urandom, 4'($urandom_range(0, 3)));
         add_req(1, $urandom, 4'($urandom_range(0, 3)));
         run_txn(1'b0, -1, -1);
         run_txn(1'b0, -1, -1);
      end
      add_req(0, 32'h0000_0010, 4'd0);
      run_txn(1'b0, -1, -1);
      // write burst of 4 with a fetch waiting behind it
      add_req(2, $urandom, 4'd3);
      add_req(0, $urandom, 4'd1);
      run_txn(1'b0, -1, -1);
      drain();
      add_req(0, $urandom, 4'd2);
      run_txn(1'b0, 5, -1);
      drain();
      add_req(1, $urandom, 4'd7);
      run_txn(1'b0, -1, 1);
      add_req(1, $urandom, 4'($urandom_range(0, 7)));
      run_txn(1'b0, -1, -1);
      drain();
      add_req(0, $urandom, 4'd1);
      add_req(1, $urandom, 4'd1);
      add_req(2, $urandom, 4'd1);
      run_txn(1'b0, -1, -1);
      run_txn(1'b0, -1, -1);
      run_txn(1'b0, -1, -1);
      for (int r = 0; r < 40; r++) begin
         if (!(pend[0] || pend[1] || pend[2])) add_req($urandom_range(0, 2), $urandom, 4'($urandom_range(0, 7)));
         run_txn(1'b1, -1, -1);
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end
endmodule
